// File: rtl/bc_seq_ctrl_if.sv
// Handshake and datapath-control bundle for bc_seq_ctrl.
// The sequencer sits on the slave side; the job issuer and consumer sit on the master side.
interface bc_seq_ctrl_if #(
  parameter int ITER_W = 4
);
  logic              start;
  logic [ITER_W-1:0] n_iter;
  logic              abort;
  logic              res_ready;
  logic              busy;
  logic              res_valid;
  logic              done;
  logic [ITER_W-1:0] iter_idx;
  logic              LX;
  logic              LS;
  logic              LH;
  logic              H;
  logic [1:0]        M0;
  logic [1:0]        M1;
  logic [1:0]        M2;

  modport slave (
    input  start, n_iter, abort, res_ready,
    output busy, res_valid, done, iter_idx, LX, LS, LH, H, M0, M1, M2
  );

  modport master (
    output start, n_iter, abort, res_ready,
    input  busy, res_valid, done, iter_idx, LX, LS, LH, H, M0, M1, M2
  );
endinterface

// File: rtl/bc_seq_ctrl.sv
// Start/busy/done sequencer running the 5-step polynomial microprogram n_iter times per job.
// Optional single-step debug port enabled by defining BC_STEP_EN.
module bc_seq_ctrl #(
  parameter int ITER_W = 4
) (
  input  logic         clk,
  input  logic         reset,
`ifdef BC_STEP_EN
  input  logic         step,
`endif
  bc_seq_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    S1     = 4'd1,
    S2     = 4'd2,
    S3     = 4'd3,
    S4     = 4'd4,
    S5     = 4'd5,
    RESULT = 4'd6,
    DONE   = 4'd7
  } state_t;

  typedef struct packed {
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       lx;
    logic       ls;
    logic       lh;
    logic       h;
  } ctrl_t;

  function automatic ctrl_t ctrl_word(input state_t s);
    ctrl_t w;
    w = '0;
    case (s)
      S1:      w = {2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1};
      S2:      w = {2'd1, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1};
      S3:      w = {2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1};
      S4:      w = {2'd0, 2'd2, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0};
      S5:      w = {2'd3, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
      default: w = '0;
    endcase
    return w;
  endfunction

  state_t            state;
  ctrl_t             ctrl_q;
  logic              busy_q;
  logic              res_valid_q;
  logic              done_q;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] n_lat;
  logic              adv;

`ifdef BC_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ctrl_q      <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      iter_q      <= '0;
      n_lat       <= '0;
    end else begin
      done_q <= 1'b0;
      // Abort beats every other transition, including a RESULT handshake.
      if (abort_active()) begin
        state       <= IDLE;
        ctrl_q      <= '0;
        busy_q      <= 1'b0;
        res_valid_q <= 1'b0;
        iter_q      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              if (bus.n_iter != '0) begin
                n_lat  <= bus.n_iter;
                iter_q <= '0;
                busy_q <= 1'b1;
                state  <= S1;
                ctrl_q <= ctrl_word(S1);
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          S1, S2, S3, S4: begin
            if (adv) begin
              state  <= state_t'(state + 4'd1);
              ctrl_q <= ctrl_word(state_t'(state + 4'd1));
            end
          end
          S5: begin
            if (adv) begin
              state       <= RESULT;
              ctrl_q      <= '0;
              res_valid_q <= 1'b1;
            end
          end
          RESULT: begin
            if (bus.res_ready) begin
              res_valid_q <= 1'b0;
              if (iter_q == n_lat - ITER_W'(1)) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                iter_q <= iter_q + ITER_W'(1);
                state  <= S1;
                ctrl_q <= ctrl_word(S1);
              end
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
            iter_q <= '0;
          end
          default: begin
            state       <= IDLE;
            ctrl_q      <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            iter_q      <= '0;
          end
        endcase
      end
    end
  end

  function automatic logic abort_active();
    return bus.abort && (state != IDLE);
  endfunction

  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.done      = done_q;
  assign bus.iter_idx  = iter_q;
  assign bus.M0        = ctrl_q.m0;
  assign bus.M1        = ctrl_q.m1;
  assign bus.M2        = ctrl_q.m2;
  assign bus.H         = ctrl_q.h;

`ifdef BC_STEP_EN
  // Loads fire only on the advancing cycle so a stalled step never reloads a register.
  assign bus.LX = ctrl_q.lx & step;
  assign bus.LS = ctrl_q.ls & step;
  assign bus.LH = ctrl_q.lh & step;
`else
  assign bus.LX = ctrl_q.lx;
  assign bus.LS = ctrl_q.ls;
  assign bus.LH = ctrl_q.lh;
`endif

endmodule
